writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// ============================================================================
// Module   : writeback_queue
// Brief    : 4-entry in-order writeback queue merging load and ALU results,
//            optional forwarding lookups (WRITEBACK_QUEUE_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [2:0]  alu_reg,
  input  logic [15:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [2:0]  mem_reg,
  input  logic [15:0] mem_data,
  output logic        mem_ready,
  output logic        write,
  output logic [2:0]  wreg,
  output logic [15:0] wd,
  input  logic [2:0]  qreg1,
  input  logic [2:0]  qreg2,
  output logic        fwd_hit1,
  output logic [15:0] fwd_data1,
  output logic        fwd_hit2,
  output logic [15:0] fwd_data2,
  output logic [2:0]  count
);

  localparam logic [2:0] c_depth = 3'd4;

  logic [2:0]  r_reg  [4];
  logic [15:0] r_data [4];
  logic [1:0]  r_head;
  logic [1:0]  r_tail;
  logic [2:0]  r_count;

  logic        w_mem_acc;
  logic        w_alu_acc;
  logic        w_deq;
  logic [1:0]  w_alu_slot;
  logic [2:0]  w_count_nxt;
  logic [3:0]  w_alu_need;

  // Readiness looks only at the registered count; both offers are refused in reset.
  assign w_alu_need  = {1'b0, r_count} + {3'b000, mem_valid};
  assign mem_ready   = rst & (r_count < c_depth);
  assign alu_ready   = rst & (w_alu_need < {1'b0, c_depth});
  assign w_mem_acc   = mem_valid & mem_ready;
  assign w_alu_acc   = alu_valid & alu_ready;
  assign w_deq       = (r_count != 3'd0);
  assign w_alu_slot  = r_tail + {1'b0, w_mem_acc};
  assign w_count_nxt = r_count + {2'b00, w_mem_acc} + {2'b00, w_alu_acc} - {2'b00, w_deq};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      r_count <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        r_reg[i]  <= 3'd0;
        r_data[i] <= 16'd0;
      end
    end else begin
      if (w_mem_acc) begin
        r_reg[r_tail]  <= mem_reg;
        r_data[r_tail] <= mem_data;
      end
      if (w_alu_acc) begin
        r_reg[w_alu_slot]  <= alu_reg;
        r_data[w_alu_slot] <= alu_data;
      end
      r_tail <= r_tail + {1'b0, w_mem_acc} + {1'b0, w_alu_acc};
      if (w_deq) begin
        r_head <= r_head + 2'd1;
      end
      r_count <= w_count_nxt;
    end
  end

  assign count = r_count;
  assign write = w_deq;
  assign wreg  = w_deq ? r_reg[r_head]  : 3'd0;
  assign wd    = w_deq ? r_data[r_head] : 16'd0;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
  logic [1:0] w_slot_idx  [4];
  logic       w_slot_live [4];

  // Slot i is the i-th oldest pending entry; live when it lies below count.
  for (genvar g = 0; g < 4; g++) begin : g_slot
    assign w_slot_idx[g]  = r_head + 2'(g);
    assign w_slot_live[g] = (3'(g) < r_count);
  end

  // Scan oldest to youngest so the youngest match overrides earlier ones.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = 16'd0;
    fwd_hit2  = 1'b0;
    fwd_data2 = 16'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_slot_live[i] && (r_reg[w_slot_idx[i]] == qreg1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = r_data[w_slot_idx[i]];
      end
      if (w_slot_live[i] && (r_reg[w_slot_idx[i]] == qreg2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = r_data[w_slot_idx[i]];
      end
    end
  end
`else
  logic w_unused_q;

  assign w_unused_q = ^{qreg1, qreg2};
  assign fwd_hit1   = 1'b0;
  assign fwd_data1  = 16'd0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data2  = 16'd0;
`endif

endmodule

`default_nettype wire
